// File: rtl/seq_left_shifter_pkg.sv
// Shared types and constants for the sequential left shifter.
package shift_pkg;

  // Datapath width used when the top is not overridden.
  localparam int unsigned DEFAULT_WIDTH = 32;

  // Control states: waiting for an operand, stepping stages, holding a result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shiftStateT;

  // True when w is a power of two within the supported datapath range.
  function automatic bit widthSupported(input int unsigned w);
    return (w >= 8) && (w <= 64) && ((w & (w - 1)) == 0);
  endfunction

endpackage

// File: rtl/seq_left_shifter_if.sv
// Operand request / result handshake bundle for the sequential left shifter.
interface seq_left_shifter_if
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic [SHW-1:0]   shamt;
  logic             rotate;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;

  // Producer/consumer side that feeds operands and takes results.
  modport master (
    output in_valid, data_in, shamt, rotate, out_ready,
    input  in_ready, out_valid, data_out
  );

  // Shifter side.
  modport slave (
    input  in_valid, data_in, shamt, rotate, out_ready,
    output in_ready, out_valid, data_out
  );

endinterface

// File: rtl/seq_left_shifter_stage.sv
// One conditional left shift or rotate by 2^k; purely combinational.
module left_shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]         value,
  input  logic [$clog2(WIDTH)-1:0] k,
  input  logic                     enable,
  input  logic                     rotate,
  output logic [WIDTH-1:0]         result
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [SHW:0]         amount;
  logic [2*WIDTH-1:0]   doubled;
  logic [2*WIDTH-1:0]   shifted;

  // Upper half of {value, fill} << 2^k: fill = value wraps for rotate, zeros otherwise.
  always_comb begin
    amount  = (SHW + 1)'(1) << k;
    doubled = {value, (rotate ? value : {WIDTH{1'b0}})};
    shifted = doubled << amount;
    result  = enable ? shifted[2*WIDTH-1 -: WIDTH] : value;
  end

endmodule

// File: rtl/seq_left_shifter.sv
// Sequential barrel shifter: one 2^k stage per cycle, SHW cycles per operand.
module seq_left_shifter
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clock,
  input  logic               reset_n,
  seq_left_shifter_if.slave  bus
);

  localparam int unsigned SHW = $clog2(WIDTH);

  shiftStateT       state;
  logic [SHW-1:0]   counter;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   shamtQ;
  logic             rotateQ;
  logic [WIDTH-1:0] dataOut;
  logic             inReady;
  logic             outValid;
  logic [WIDTH-1:0] stageOut;

  // Single shared stage; the counter selects which power of two it applies.
  left_shift_stage #(.WIDTH(WIDTH)) stage (
    .value  (work),
    .k      (counter),
    .enable (shamtQ[counter]),
    .rotate (rotateQ),
    .result (stageOut)
  );

  // Control FSM with registered handshake flags and result register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      counter  <= '0;
      work     <= '0;
      shamtQ   <= '0;
      rotateQ  <= 1'b0;
      dataOut  <= '0;
      inReady  <= 1'b0;
      outValid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          inReady  <= 1'b1;
          outValid <= 1'b0;
          // inReady is still 0 on the first edge after reset, so nothing is taken then.
          if (bus.in_valid && inReady) begin
            work    <= bus.data_in;
            shamtQ  <= bus.shamt;
            rotateQ <= bus.rotate;
            counter <= SHW'(SHW - 1);
            inReady <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          work <= stageOut;
          if (counter == '0) begin
            dataOut  <= stageOut;
            outValid <= 1'b1;
            state    <= DONE;
          end else begin
            counter <= counter - SHW'(1);
          end
        end
        DONE: begin
          // Returning to IDLE here means the earliest next accept is one edge later.
          if (bus.out_ready) begin
            outValid <= 1'b0;
            inReady  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          inReady  <= 1'b0;
          outValid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.data_out  = dataOut;

endmodule

// File: tb/tb_seq_left_shifter.sv
// Self-checking bench for seq_left_shifter at WIDTH=32.
module tb_seq_left_shifter;

  localparam int unsigned W = 32;
  localparam int RAND_OPS = 3000;

  logic clk;
  logic rstN;
  int   nChecks = 0;
  int   nFails  = 0;

  seq_left_shifter_if #(.WIDTH(W)) bus ();

  seq_left_shifter #(.WIDTH(W)) dut (
    .clock   (clk),
    .reset_n (rstN),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  s;
    logic        r;
    logic [31:0] exp;
  } vecT;

  vecT vecs[8];

  // Reference: plain 64-bit arithmetic of the shift/rotate definition.
  function automatic logic [31:0] refShift(input logic [31:0] d, input logic [4:0] s, input logic r);
    logic [63:0] x;
    x = {32'h0, d} << s;
    return x[31:0] | (r ? x[63:32] : 32'h0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operand, wait (bounded) until accepted, then drop in_valid.
  task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic r);
    int n;
    n = 0;
    bus.data_in  = d;
    bus.shamt    = s;
    bus.rotate   = r;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("acceptTimeout", 64'(n), 64'(0));
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Count cycles from the accept edge until out_valid; optional noise on unused inputs.
  task automatic waitDone(input bit noise, output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      if (noise) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.data_in   = $urandom;
        bus.shamt     = 5'($urandom_range(0, 31));
        bus.rotate    = 1'($urandom_range(0, 1));
      end
      tick();
      lat++;
    end
    if (noise) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int bad;
    logic [31:0] d;
    logic [4:0]  s;
    logic        r;
    logic [31:0] held;

    vecs[0] = '{32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000};
    vecs[1] = '{32'h8000_0001, 5'd4,  1'b1, 32'h0000_0018};
    vecs[2] = '{32'h8000_0001, 5'd4,  1'b0, 32'h0000_0010};
    vecs[3] = '{32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF};
    vecs[4] = '{32'h1234_5678, 5'd8,  1'b0, 32'h3456_7800};
    vecs[5] = '{32'h1234_5678, 5'd8,  1'b1, 32'h3456_7812};
    vecs[6] = '{32'hF000_000F, 5'd16, 1'b1, 32'h000F_F000};
    vecs[7] = '{32'hFFFF_FFFF, 5'd31, 1'b0, 32'h8000_0000};

    rstN          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.data_in   = '0;
    bus.shamt     = '0;
    bus.rotate    = 1'b0;

    // Reset state, including an offered operand that must be ignored.
    #3;
    check("rstInReady", 64'(bus.in_ready), 64'(0));
    check("rstOutValid", 64'(bus.out_valid), 64'(0));
    check("rstDataOut", 64'(bus.data_out), 64'(0));
    tick();
    tick();
    @(negedge clk);
    rstN = 1'b1;
    #1;
    check("relInReadyBeforeEdge", 64'(bus.in_ready), 64'(0));
    tick();
    check("relInReadyAfterEdge", 64'(bus.in_ready), 64'(1));

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].d, vecs[i].s, vecs[i].r);
      waitDone(1'b0, lat);
      check($sformatf("vec%0dLatency", i), 64'(lat), 64'(5));
      check($sformatf("vec%0dData", i), 64'(bus.data_out), 64'(vecs[i].exp));
      consume();
    end

    // out_ready tied high: in_ready low until consume, no accept on the consume edge.
    tick();
    bus.out_ready = 1'b1;
    issue(32'hDEAD_BEEF, 5'd0, 1'b0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad++;
      tick();
    end
    check("tiedBusyCycles", 64'(bad), 64'(0));
    check("tiedOutValid", 64'(bus.out_valid), 64'(1));
    check("tiedData", 64'(bus.data_out), 64'hDEAD_BEEF);
    check("tiedInReadyInDone", 64'(bus.in_ready), 64'(0));
    bus.in_valid = 1'b1;
    bus.data_in  = 32'h0000_00FF;
    tick();
    check("tiedInReadyAfterConsume", 64'(bus.in_ready), 64'(1));
    check("tiedOutValidAfterConsume", 64'(bus.out_valid), 64'(0));
    bus.in_valid = 1'b0;
    tick();
    check("noAcceptOnConsumeEdge", 64'(bus.in_ready), 64'(1));
    bus.out_ready = 1'b0;

    // Input changes in SHIFT ignored; long output stall holds data.
    issue(32'h0000_0001, 5'd3, 1'b0);
    bus.data_in = 32'hFFFF_FFFF;
    bus.shamt   = 5'd0;
    bus.rotate  = 1'b1;
    waitDone(1'b0, lat);
    check("stallLatency", 64'(lat), 64'(5));
    check("stallData", 64'(bus.data_out), 64'h0000_0008);
    held = bus.data_out;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.data_out !== held || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
    end
    check("stallStable", 64'(bad), 64'(0));
    consume();
    tick();
    check("retainAfterDone", 64'(bus.data_out), 64'h0000_0008);

    // Reset two cycles into SHIFT abandons the operation.
    issue(32'hCAFE_F00D, 5'd4, 1'b0);
    tick();
    tick();
    #2;
    rstN = 1'b0;
    #1;
    check("midRstOutValid", 64'(bus.out_valid), 64'(0));
    check("midRstDataOut", 64'(bus.data_out), 64'(0));
    check("midRstInReady", 64'(bus.in_ready), 64'(0));
    tick();
    @(negedge clk);
    rstN = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) bad++;
    end
    check("midRstNoResult", 64'(bad), 64'(0));
    issue(32'h1234_5678, 5'd8, 1'b0);
    waitDone(1'b0, lat);
    check("postRstLatency", 64'(lat), 64'(5));
    check("postRstData", 64'(bus.data_out), 64'h3456_7800);
    consume();

    // Randomized operands with stalls and noise on ignored inputs.
    for (int n = 0; n < RAND_OPS; n++) begin
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      r = 1'($urandom_range(0, 1));
      for (int j = $urandom_range(0, 2); j > 0; j--) tick();
      issue(d, s, r);
      waitDone(1'b1, lat);
      check("randLatency", 64'(lat), 64'(5));
      check("randData", 64'(bus.data_out), 64'(refShift(d, s, r)));
      for (int j = $urandom_range(0, 3); j > 0; j--) tick();
      check("randHeld", 64'(bus.data_out), 64'(refShift(d, s, r)));
      consume();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
